// File: rtl/ray_dispatcher.sv
// Raster-order primary-ray dispatcher: one pixel per cycle into the ray core, counts retirements, flags end of frame.
// Optional build macro RAY_DISPATCH_PERF_EN adds stall_cycles / frame_cycles performance counters.

package ray_dispatcher_pkg;
   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [7:0]  sample_id;
      logic [7:0]  flags;
   } RasterInputData;
endpackage

module ray_dispatcher
   import ray_dispatcher_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 240,
   parameter int X_WIDTH       = 9,
   parameter int Y_WIDTH       = 8,
   parameter int CNT_WIDTH     = 17
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           fifo_full,
   output logic           add_input,
   output RasterInputData input_data,
   input  logic           core_valid,
   output logic           busy,
   output logic           frame_done,
   output logic           overrun
`ifdef RAY_DISPATCH_PERF_EN
   ,
   output logic [31:0]    stall_cycles,
   output logic [31:0]    frame_cycles
`endif
);

   localparam logic [X_WIDTH-1:0]   X_LAST  = X_WIDTH'(SCREEN_WIDTH - 1);
   localparam logic [Y_WIDTH-1:0]   Y_LAST  = Y_WIDTH'(SCREEN_HEIGHT - 1);
   localparam logic [CNT_WIDTH-1:0] TOTAL_C = CNT_WIDTH'(SCREEN_WIDTH * SCREEN_HEIGHT);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                state, state_nxt;
   logic [X_WIDTH-1:0]    x;
   logic [Y_WIDTH-1:0]    y;
   logic [CNT_WIDTH-1:0]  issued, retired, retired_nxt;
   logic                  push, last_px, retire_ok, frame_start;

   always_comb begin
      state_nxt   = state;
      push        = (state == ISSUE) && !fifo_full;
      last_px     = (x == X_LAST) && (y == Y_LAST);
      frame_start = (state == IDLE) && start;
      // A completion only counts while something is actually outstanding.
      retire_ok   = core_valid && ((state == ISSUE) || (state == DRAIN)) && (retired != issued);
      retired_nxt = retired + CNT_WIDTH'(retire_ok);
      case (state)
         IDLE:    if (start) state_nxt = ISSUE;
         ISSUE:   if (push && last_px) state_nxt = DRAIN;
         DRAIN:   if (retired_nxt == TOTAL_C) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         x       <= '0;
         y       <= '0;
         issued  <= '0;
         retired <= '0;
         overrun <= 1'b0;
      end else begin
         state <= state_nxt;
         if (frame_start) begin
            x       <= '0;
            y       <= '0;
            issued  <= '0;
            retired <= '0;
         end else begin
            // The final pixel leaves x/y parked on the last coordinate.
            if (push && !last_px) begin
               if (x == X_LAST) begin
                  x <= '0;
                  y <= y + Y_WIDTH'(1);
               end else begin
                  x <= x + X_WIDTH'(1);
               end
            end
            if (push)
               issued <= issued + CNT_WIDTH'(1);
            if (retire_ok)
               retired <= retired_nxt;
         end
         if (core_valid && !retire_ok)
            overrun <= 1'b1;
      end
   end

   always_comb begin
      input_data   = '0;
      input_data.x = 16'(x);
      input_data.y = 16'(y);
   end

   assign add_input  = push;
   assign busy       = (state == ISSUE) || (state == DRAIN);
   assign frame_done = (state == DONE);

`ifdef RAY_DISPATCH_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         frame_cycles <= '0;
      end else if (frame_start) begin
         stall_cycles <= '0;
         frame_cycles <= '0;
      end else begin
         if ((state == ISSUE) && fifo_full)
            stall_cycles <= sat_inc(stall_cycles);
         if (busy)
            frame_cycles <= sat_inc(frame_cycles);
      end
   end
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher on a 4x2 screen with a 5-cycle echoing core model.
// Build with RAY_DISPATCH_PERF_EN defined to also check the performance counters.

module tb_ray_dispatcher;
   import ray_dispatcher_pkg::*;

   localparam int W   = 4;
   localparam int H   = 2;
   localparam int LAT = 5;

   logic clk = 1'b0;
   logic reset, start, fifo_full, core_valid;
   logic add_input, busy, frame_done, overrun;
   RasterInputData input_data;
`ifdef RAY_DISPATCH_PERF_EN
   logic [31:0] stall_cycles, frame_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc, n_push, n_done, done_cyc, last_valid_cyc, busy_cycles;
   int order_err, full_push, first_push_cyc, third_push_cyc, last_push_cyc;
   int stall_after, stall_left;
   bit echo_en, inj_valid;
   bit push_hist [0:255];
   RasterInputData exp_d;

   ray_dispatcher #(
      .SCREEN_WIDTH (W),
      .SCREEN_HEIGHT(H),
      .X_WIDTH      (9),
      .Y_WIDTH      (8),
      .CNT_WIDTH    (17)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .fifo_full (fifo_full),
      .add_input (add_input),
      .input_data(input_data),
      .core_valid(core_valid),
      .busy      (busy),
      .frame_done(frame_done),
      .overrun   (overrun)
`ifdef RAY_DISPATCH_PERF_EN
      ,
      .stall_cycles(stall_cycles),
      .frame_cycles(frame_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, sample mid-cycle, advance to 1ns past the next edge.
   task automatic step();
      fifo_full = (stall_left > 0) && (n_push == stall_after);
      if (fifo_full) stall_left--;
      core_valid = inj_valid || (echo_en && cyc >= LAT && cyc - LAT < 256 && push_hist[cyc-LAT]);
      #1;
      if (cyc < 256) push_hist[cyc] = add_input;
      if (add_input) begin
         exp_d   = '0;
         exp_d.x = 16'(n_push % W);
         exp_d.y = 16'(n_push / W);
         if (input_data !== exp_d) order_err++;
         if (fifo_full) full_push++;
         if (n_push == 0) first_push_cyc = cyc;
         if (n_push == 2) third_push_cyc = cyc;
         last_push_cyc = cyc;
         n_push++;
      end
      if (core_valid) last_valid_cyc = cyc;
      if (busy) busy_cycles++;
      if (frame_done) begin
         n_done++;
         done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      start     = 1'b0;
      inj_valid = 1'b0;
   endtask

   task automatic reset_stats();
      cyc = 0; n_push = 0; n_done = 0; done_cyc = -1; last_valid_cyc = -1;
      busy_cycles = 0; order_err = 0; full_push = 0;
      first_push_cyc = -1; third_push_cyc = -1; last_push_cyc = -1;
      stall_after = -1; stall_left = 0; echo_en = 1'b1;
      for (int i = 0; i < 256; i++) push_hist[i] = 1'b0;
   endtask

   task automatic run_frame(input int stalls, input int mid_a, input int mid_b, input int inj);
      reset_stats();
      stall_after = 2;
      stall_left  = stalls;
      while (n_done == 0 && cyc < 60) begin
         start     = (cyc == 0) || (cyc == mid_a) || (cyc == mid_b);
         inj_valid = (cyc == inj);
         step();
      end
      repeat (4) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; start = 1'b0; fifo_full = 1'b0; core_valid = 1'b0;
      inj_valid = 1'b0;
      reset_stats();
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_add_input", add_input, 0);
      check("rst_input_data_zero", input_data == '0, 1);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overrun", overrun, 0);
`ifdef RAY_DISPATCH_PERF_EN
      check("rst_stall_cycles", stall_cycles, 0);
      check("rst_frame_cycles", frame_cycles, 0);
`endif
      reset = 1'b0;
      repeat (2) step();

      // Plain frame
      run_frame(0, -1, -1, -1);
      check("t1_pushes", n_push, 8);
      check("t1_order", order_err, 0);
      check("t1_first_push_cyc", first_push_cyc, 1);
      check("t1_last_push_cyc", last_push_cyc, 8);
      check("t1_done_pulses", n_done, 1);
      check("t1_done_cyc", done_cyc, 14);
      check("t1_done_after_retire", done_cyc - last_valid_cyc, 1);
      check("t1_busy_cycles", busy_cycles, 13);
      check("t1_overrun", overrun, 0);

      // Three stall cycles after the second push
      run_frame(3, -1, -1, -1);
      check("t2_pushes", n_push, 8);
      check("t2_order", order_err, 0);
      check("t2_push_while_full", full_push, 0);
      check("t2_third_push_cyc", third_push_cyc, 6);
      check("t2_done_pulses", n_done, 1);
      check("t2_done_cyc", done_cyc, 17);
`ifdef RAY_DISPATCH_PERF_EN
      check("t2_stall_cycles", stall_cycles, 3);
      check("t2_frame_cycles", frame_cycles, 16);
`endif

      // start re-asserted mid-ISSUE and mid-DRAIN
      run_frame(0, 3, 11, -1);
      check("t3_pushes", n_push, 8);
      check("t3_order", order_err, 0);
      check("t3_done_pulses", n_done, 1);
      check("t3_done_cyc", done_cyc, 14);
      check("t3_busy_cycles", busy_cycles, 13);
`ifdef RAY_DISPATCH_PERF_EN
      check("t3_stall_cycles", stall_cycles, 0);
      check("t3_frame_cycles", frame_cycles, 13);
`endif

      // core_valid while nothing outstanding inside a frame
      run_frame(0, -1, -1, 1);
      check("t5b_overrun", overrun, 1);
      check("t5b_pushes", n_push, 8);
      check("t5b_done_pulses", n_done, 1);
      check("t5b_done_cyc", done_cyc, 14);

      // Reset mid-ISSUE after three pushes
      reset_stats();
      echo_en = 1'b0;
      start = 1'b1;
      step();
      repeat (3) step();
      fifo_full  = 1'b0;
      core_valid = 1'b0;
      #1;
      check("t4_add_before_rst", add_input, 1);
      check("t4_busy_before_rst", busy, 1);
      reset = 1'b1;
      #1;
      check("t4_add_async", add_input, 0);
      check("t4_busy_async", busy, 0);
      check("t4_overrun_cleared", overrun, 0);
      #1 reset = 1'b0;
      repeat (4) step();
      check("t4_abort_pushes", n_push, 3);
      check("t4_abort_no_done", n_done, 0);
      run_frame(0, -1, -1, -1);
      check("t4_restart_order", order_err, 0);
      check("t4_restart_first_cyc", first_push_cyc, 1);
      check("t4_restart_pushes", n_push, 8);
      check("t4_restart_done", n_done, 1);
      check("t4_restart_overrun", overrun, 0);

      // core_valid while IDLE, then a full frame
      inj_valid = 1'b1;
      step();
      check("t5a_overrun_set", overrun, 1);
      repeat (3) step();
      check("t5a_overrun_sticky", overrun, 1);
      run_frame(0, -1, -1, -1);
      check("t5a_done_pulses", n_done, 1);
      check("t5a_done_cyc", done_cyc, 14);
      check("t5a_overrun_after_frame", overrun, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
